// File: rtl/mlaccel_top.sv
// mlaccel_top -- QPI slave front end with an on-chip byte memory.
//
// A host talks to the block over a 4-bit QPI bus that is asynchronous to
// `clock`. Every QPI input is brought into the clock domain through a
// 2-flop synchronizer. qpi_clk edges are then detected on the synchronized
// copy. A byte is two nibbles, with the high nibble first. The first byte
// after csb falls is the opcode:
//   0x05 status : returns {6'b0, qpi_err, 1'b1} for every byte clocked
//   0x02 write  : 2 address bytes (MSB first), then data bytes, post-increment
//   0x03 read   : 2 address bytes, 1 dummy byte, then data bytes, post-increment
//   0x01 clear  : clears qpi_err, rest of transaction ignored
//   other       : sets qpi_err, rest of transaction ignored
//
// Ports
//   clock           system clock, rising edge
//   reset           synchronous active-high reset
//   qpi_csb         active-low chip select (asynchronous)
//   qpi_clk         QPI serial clock (asynchronous)
//   qpi_io0..3      bidirectional data nibble, qpi_io3 = MSB
//   qpi_rdy         high while idle with csb deasserted
//   qpi_err         sticky protocol-error flag
`timescale 1ns/1ps

module mlaccel_top #(
  parameter int MEM_BYTES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic qpi_csb,
  input  logic qpi_clk,
  inout  wire  qpi_io0,
  inout  wire  qpi_io1,
  inout  wire  qpi_io2,
  inout  wire  qpi_io3,
  output logic qpi_rdy,
  output logic qpi_err
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE
  } state_t;

  // ------------------------------------------------------------------
  // Synchronizers and qpi_clk edge detection
  // ------------------------------------------------------------------
  logic       csb_s1, csb_s2;
  logic       qclk_s1, qclk_s2, qclk_d;
  logic [3:0] io_s1, io_s2;

  // NOTE: synchronizer flops carry no reset. They track the pins even while
  // reset is held, so their outputs are valid when reset releases.
  always_ff @(posedge clock) begin
    csb_s1  <= qpi_csb;
    csb_s2  <= csb_s1;
    qclk_s1 <= qpi_clk;
    qclk_s2 <= qclk_s1;
    qclk_d  <= qclk_s2;
    io_s1   <= {qpi_io3, qpi_io2, qpi_io1, qpi_io0};
    io_s2   <= io_s1;
  end

  logic qclk_rise, qclk_fall;
  assign qclk_rise =  qclk_s2 & ~qclk_d;
  assign qclk_fall = ~qclk_s2 &  qclk_d;

  // ------------------------------------------------------------------
  // Protocol state
  // ------------------------------------------------------------------
  state_t          state;
  logic            csb_seen_high;  // csb observed high in IDLE; arms the next fall
  logic            nib_lo;         // next input nibble is the low nibble
  logic [3:0]      hi_nib;
  logic            addr_cnt;       // 0: expecting address MSB, 1: LSB
  logic [7:0]      addr_hi;
  logic [AW-1:0]   addr;
  logic            op_write;
  logic            rd_status;      // RDATA returns the status byte, not memory
  logic            out_lo;         // next output nibble is the low nibble
  logic            io_oe;
  logic [3:0]      io_out;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      wr_data;
  logic [7:0]      rd_data;

  logic [7:0]      rx_byte;
  logic [16:0]     addr_ext;
  logic [7:0]      tx_byte;

  assign rx_byte  = {hi_nib, io_s2};
  assign addr_ext = {1'b0, addr_hi, rx_byte};
  assign tx_byte  = rd_status ? {6'b0, qpi_err, 1'b1} : rd_data;

  // Address bits above the memory depth are dropped (address mod MEM_BYTES).
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_ext[16:AW]};

  // NOTE: all sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      csb_seen_high <= 1'b0;   // a transaction in flight stays ignored
      nib_lo        <= 1'b0;
      hi_nib        <= 4'h0;
      addr_cnt      <= 1'b0;
      addr_hi       <= 8'h00;
      addr          <= '0;
      op_write      <= 1'b0;
      rd_status     <= 1'b0;
      out_lo        <= 1'b0;
      io_oe         <= 1'b0;
      io_out        <= 4'h0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= 8'h00;
      qpi_rdy       <= 1'b1;
      qpi_err       <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      qpi_rdy <= (state == IDLE) && csb_s2;

      if (state == IDLE) begin
        io_oe         <= 1'b0;
        csb_seen_high <= csb_s2;
        if (csb_seen_high && !csb_s2) begin
          state  <= CMD;
          nib_lo <= 1'b0;
        end
      end else if (csb_s2) begin
        // csb released: abort whatever is in progress, drop partial bytes.
        state         <= IDLE;
        io_oe         <= 1'b0;
        nib_lo        <= 1'b0;
        csb_seen_high <= 1'b1;
      end else begin
        // Input nibbles are sampled on qpi_clk rising edges, except in RDATA
        // where the block owns the bus.
        if (qclk_rise && state != RDATA) begin
          if (!nib_lo) begin
            hi_nib <= io_s2;
            nib_lo <= 1'b1;
          end else begin
            nib_lo <= 1'b0;
            unique case (state)
              CMD: begin
                case (rx_byte)
                  OP_STATUS: begin
                    state     <= RDATA;
                    rd_status <= 1'b1;
                    out_lo    <= 1'b0;
                  end
                  OP_WRITE: begin
                    state    <= ADDR;
                    op_write <= 1'b1;
                    addr_cnt <= 1'b0;
                  end
                  OP_READ: begin
                    state    <= ADDR;
                    op_write <= 1'b0;
                    addr_cnt <= 1'b0;
                  end
                  OP_CLEAR: begin
                    state   <= IGNORE;
                    qpi_err <= 1'b0;
                  end
                  default: begin
                    state   <= IGNORE;
                    qpi_err <= 1'b1;
                  end
                endcase
              end
              ADDR: begin
                if (!addr_cnt) begin
                  addr_hi  <= rx_byte;
                  addr_cnt <= 1'b1;
                end else begin
                  addr  <= addr_ext[AW-1:0];
                  state <= op_write ? WDATA : DUMMY;
                end
              end
              DUMMY: begin
                state     <= RDATA;
                rd_status <= 1'b0;
                out_lo    <= 1'b0;
              end
              WDATA: begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= rx_byte;
                addr    <= addr + 1'b1;
              end
              default: ;  // IGNORE (IDLE/RDATA never reach here)
            endcase
          end
        end

        // Output nibbles change on qpi_clk falling edges so they are stable
        // at the rising edge where the host samples them.
        if (qclk_fall && state == RDATA) begin
          io_oe <= 1'b1;
          if (!out_lo) begin
            io_out <= tx_byte[7:4];
            out_lo <= 1'b1;
          end else begin
            io_out <= tx_byte[3:0];
            out_lo <= 1'b0;
            if (!rd_status) addr <= addr + 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Byte memory: one write port, registered read of the current address.
  // The read data is consumed at least three cycles after addr settles.
  // ------------------------------------------------------------------
  logic [7:0] mem [MEM_BYTES];

  // NOTE: the memory array is deliberately not reset; its contents survive
  // reset and it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[addr];
  end

  assign qpi_io0 = io_oe ? io_out[0] : 1'bz;
  assign qpi_io1 = io_oe ? io_out[1] : 1'bz;
  assign qpi_io2 = io_oe ? io_out[2] : 1'bz;
  assign qpi_io3 = io_oe ? io_out[3] : 1'bz;

endmodule

// File: tb/tb_mlaccel_top.sv
// Testbench for mlaccel_top: a behavioural QPI host plus a byte-memory model.
// Expected read bytes are pushed to a scoreboard queue when a read or status
// command is issued. They are popped and compared as the DUT returns bytes.
`timescale 1ns/1ps

module tb_mlaccel_top;

  localparam int PH = 60;  // qpi_clk half period: 6 system clocks

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       qpi_csb  = 1'b1;
  logic       qpi_clk  = 1'b0;
  logic       host_oe  = 1'b0;
  logic [3:0] host_dat = 4'h0;
  logic       qpi_rdy;
  logic       qpi_err;
  wire        qpi_io0, qpi_io1, qpi_io2, qpi_io3;
  wire  [3:0] bus;

  int         total = 0;
  int         bad   = 0;

  logic [7:0] model [4096];
  logic       err_m = 1'b0;
  logic [7:0] sb    [$];
  logic [7:0] got_q [$];

  always #5 clock = ~clock;

  // A released bus floats high, so any DUT drive of a zero bit is visible.
  pullup (qpi_io0);
  pullup (qpi_io1);
  pullup (qpi_io2);
  pullup (qpi_io3);

  assign qpi_io0 = host_oe ? host_dat[0] : 1'bz;
  assign qpi_io1 = host_oe ? host_dat[1] : 1'bz;
  assign qpi_io2 = host_oe ? host_dat[2] : 1'bz;
  assign qpi_io3 = host_oe ? host_dat[3] : 1'bz;
  assign bus     = {qpi_io3, qpi_io2, qpi_io1, qpi_io0};

  mlaccel_top #(.MEM_BYTES(4096)) dut (
    .clock   (clock),
    .reset   (reset),
    .qpi_csb (qpi_csb),
    .qpi_clk (qpi_clk),
    .qpi_io0 (qpi_io0),
    .qpi_io1 (qpi_io1),
    .qpi_io2 (qpi_io2),
    .qpi_io3 (qpi_io3),
    .qpi_rdy (qpi_rdy),
    .qpi_err (qpi_err)
  );

  // ------------------------------------------------------------------
  // Host bus primitives (all delays are multiples of the clock period,
  // so every drive and sample lands on a falling clock edge)
  // ------------------------------------------------------------------
  task automatic send_nibble(input logic [3:0] n, input bit release_bus);
    host_oe  = 1'b1;
    host_dat = n;
    #PH qpi_clk = 1'b1;
    #(PH/2);
    if (release_bus) host_oe = 1'b0;
    #(PH/2) qpi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit release_bus);
    send_nibble(b[7:4], 1'b0);
    send_nibble(b[3:0], release_bus);
  endtask

  task automatic read_nibble(output logic [3:0] n);
    #PH n = bus;
    qpi_clk = 1'b1;
    #PH qpi_clk = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [3:0] h, l;
    read_nibble(h);
    read_nibble(l);
    b = {h, l};
  endtask

  task automatic csb_start();
    qpi_csb = 1'b0;
    #PH;
  endtask

  task automatic csb_end();
    qpi_csb = 1'b1;
    host_oe = 1'b0;
    #(3*PH);
  endtask

  task automatic do_write(input logic [15:0] a, input int n,
                          input logic [7:0] d0, input logic [7:0] d1);
    csb_start();
    send_byte(8'h02, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
    send_byte(d0, 1'b0);
    model[a[11:0]] = d0;
    if (n > 1) begin
      send_byte(d1, 1'b0);
      model[a[11:0] + 12'd1] = d1;
    end
    csb_end();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [7:0] b;
    csb_start();
    send_byte(8'h03, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < n; i++) begin
      sb.push_back(model[a[11:0] + 12'(i)]);
      read_byte(b);
      got_q.push_back(b);
    end
    csb_end();
  endtask

  task automatic do_status(input int n);
    logic [7:0] b;
    csb_start();
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < n; i++) begin
      sb.push_back({6'b0, err_m, 1'b1});
      read_byte(b);
      got_q.push_back(b);
    end
    csb_end();
  endtask

  // ------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0b expected 1", qpi_rdy); end
    total++;
    if (qpi_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", qpi_err); end
    total++;
    if (bus !== 4'hF) begin bad++; $display("FAIL reset_bus: got %h expected f (released)", bus); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy: got %0b expected 1", qpi_rdy); end
    total++;
    if (qpi_err !== 1'b0) begin bad++; $display("FAIL post_reset_err: got %0b expected 0", qpi_err); end
  endtask

  task automatic test_status();
    logic [7:0] got, exp;
    do_status(2);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL status_byte: got %02h expected %02h", got, exp); end
    end
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL status_rdy: got %0b expected 1", qpi_rdy); end
  endtask

  task automatic test_write_read();
    logic [7:0] got, exp;
    do_write(16'h0010, 2, 8'hA5, 8'h3C);
    do_read(16'h0010, 2);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL write_read: got %02h expected %02h", got, exp); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got, exp;
    do_write(16'h0FFF, 2, 8'h11, 8'h22);
    do_read(16'h0000, 1);   // second write byte wrapped to 0
    do_read(16'h0FFF, 2);   // read also wraps
    do_read(16'hF010, 1);   // upper address bits are ignored
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL wrap: got %02h expected %02h", got, exp); end
    end
  endtask

  task automatic test_error();
    logic [7:0] got, exp;
    csb_start();
    send_byte(8'h7E, 1'b0);
    send_byte(8'h05, 1'b0);   // must be ignored
    send_byte(8'h00, 1'b0);
    csb_end();
    err_m = 1'b1;
    total++;
    if (qpi_err !== err_m) begin bad++; $display("FAIL err_set: got %0b expected %0b", qpi_err, err_m); end
    do_status(2);
    csb_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h7E, 1'b0);   // ignored after clear
    csb_end();
    err_m = 1'b0;
    total++;
    if (qpi_err !== err_m) begin bad++; $display("FAIL err_clear: got %0b expected %0b", qpi_err, err_m); end
    do_status(1);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL err_status: got %02h expected %02h", got, exp); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] got, exp;
    logic [3:0] nib;
    do_write(16'h0020, 2, 8'h5A, 8'h6B);
    // Write one full byte, then only the high nibble of the next one.
    csb_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'hC3, 1'b0);
    model[12'h020] = 8'hC3;
    send_nibble(4'hD, 1'b0);
    qpi_csb = 1'b1;
    host_oe = 1'b0;
    #30;
    total++;
    if (bus !== 4'hF) begin bad++; $display("FAIL abort_wr_bus: got %h expected f", bus); end
    #(3*PH);
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL abort_wr_rdy: got %0b expected 1", qpi_rdy); end
    do_read(16'h0020, 2);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL abort_mem: got %02h expected %02h", got, exp); end
    end
    // Abort a read while the DUT drives the bus; it must release in 3 clocks.
    csb_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b1);
    read_nibble(nib);
    total++;
    if (nib !== model[12'h010][7:4]) begin
      bad++; $display("FAIL abort_rd_nibble: got %h expected %h", nib, model[12'h010][7:4]);
    end
    qpi_csb = 1'b1;
    #30;
    total++;
    if (bus !== 4'hF) begin bad++; $display("FAIL abort_rd_release: got %h expected f", bus); end
    #(3*PH);
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL abort_rd_rdy: got %0b expected 1", qpi_rdy); end
  endtask

  task automatic test_bus_sharing();
    logic [3:0] pat [6];
    pat = '{4'h0, 4'h5, 4'h0, 4'h3, 4'hA, 4'h0};  // status/read opcodes on the wire
    qpi_csb = 1'b1;
    host_oe = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_dat = pat[i];
      #PH qpi_clk = 1'b1;
      #10;
      total++;
      if (bus !== pat[i]) begin bad++; $display("FAIL share_drive_hi: got %h expected %h", bus, pat[i]); end
      #(PH-10) qpi_clk = 1'b0;
      #10;
      total++;
      if (bus !== pat[i]) begin bad++; $display("FAIL share_drive_lo: got %h expected %h", bus, pat[i]); end
      #(-10 + 10);
    end
    host_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      total++;
      if (bus !== 4'hF) begin bad++; $display("FAIL share_release: got %h expected f", bus); end
    end
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL share_rdy: got %0b expected 1", qpi_rdy); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] got, exp, b;
    logic [3:0] nib;
    csb_start();
    send_byte(8'h05, 1'b1);
    sb.push_back({6'b0, err_m, 1'b1});
    read_byte(b);
    got_q.push_back(b);
    reset = 1'b1;
    err_m = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (bus !== 4'hF) begin bad++; $display("FAIL rst_abort_bus: got %h expected f", bus); end
    total++;
    if (qpi_rdy !== 1'b0) begin bad++; $display("FAIL rst_abort_rdy: got %0b expected 0", qpi_rdy); end
    // Still inside the same csb-low window: the DUT must ignore this command.
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < 2; i++) begin
      read_nibble(nib);
      total++;
      if (nib !== 4'hF) begin bad++; $display("FAIL rst_abort_idle: got %h expected f", nib); end
    end
    csb_end();
    total++;
    if (qpi_rdy !== 1'b1) begin bad++; $display("FAIL rst_abort_rdy_back: got %0b expected 1", qpi_rdy); end
    do_status(1);
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      exp = sb.pop_front();
      total++;
      if (got !== exp) begin bad++; $display("FAIL rst_abort_status: got %02h expected %02h", got, exp); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    test_status();
    test_write_read();
    test_wrap();
    test_error();
    test_abort();
    test_bus_sharing();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mlaccel_top.md
MLACCEL_TOP -- requirements
Module: mlaccel_top

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning on-chip byte memory depth (power of two).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port qpi_csb, input, 1, active-low chip select, asynchronous to clock.
REQ-005 SHALL have port qpi_clk, input, 1, QPI serial clock, asynchronous to clock.
REQ-006 SHALL have ports qpi_io0..qpi_io3, inout, 1 each, QPI data nibble; qpi_io3 is the MSB.
REQ-007 SHALL have port qpi_rdy, output, 1, high when idle and ready for a transaction.
REQ-008 SHALL have port qpi_err, output, 1, sticky protocol-error flag.

Function
REQ-009 SHALL pass qpi_csb, qpi_clk and qpi_io0..3 each through a 2-flop synchronizer into the clock domain, and detect qpi_clk edges from the synchronized value.
REQ-010 SHALL require each qpi_clk high and low phase to be at least 3 clock periods; faster qpi_clk behaviour is unspecified.
REQ-011 SHALL sample one input nibble per detected qpi_clk rising edge while synchronized csb is low; the high nibble of each byte comes first.
REQ-012 SHALL tri-state qpi_io0..3 at all times except during a read or status data phase with synchronized csb low.
REQ-013 SHALL use states IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, and IGNORE; the first byte after csb falls is the opcode.
REQ-014 SHALL, on opcode 0x05 (status), enter RDATA and return status byte {6'b0, qpi_err, 1'b1}, repeated for every further byte clocked.
REQ-015 SHALL, on opcode 0x02 (write), take 2 address bytes (MSB first), then store each following byte and post-increment the address.
REQ-016 SHALL, on opcode 0x03 (read), take 2 address bytes and 1 dummy byte, then return memory bytes with post-increment.
REQ-017 SHALL, on opcode 0x01 (clear), clear qpi_err and ignore any further bytes.
REQ-018 SHALL, on any other opcode, set qpi_err and ignore the rest of the transaction (IGNORE).
REQ-019 SHALL, in RDATA, drive each output nibble after the detected qpi_clk falling edge that precedes the rising edge at which the host samples it. The first high nibble is driven after the falling edge that follows the last opcode/dummy rising edge.
REQ-020 SHALL index memory with address mod MEM_BYTES; incrementing past MEM_BYTES-1 wraps to 0.
REQ-021 SHALL commit a write byte only when both of its nibbles are received; a partial byte at csb rise is discarded.
REQ-022 SHALL, on synchronized csb rising at any state, return to IDLE and release qpi_io0..3 within 3 clock cycles.
REQ-023 SHALL assert qpi_rdy in IDLE with synchronized csb high, and deassert it otherwise.

Reset
REQ-024 SHALL, on reset, enter IDLE, clear qpi_err, set qpi_rdy=1, tri-state qpi_io0..3, and clear the address and nibble counters.
REQ-025 SHALL let reset asserted mid-transaction abort it; the bus stays idle until csb goes high and low again.
REQ-026 SHALL leave memory contents unchanged by reset.

Verification
REQ-027 SHALL be verified with a status read after reset: opcode 0x05 -> read byte 0x01, qpi_rdy=1 after csb high.
REQ-028 SHALL be verified with a write-then-read: write 0x02, addr 0x0010, data 0xA5 0x3C; read 0x03, addr 0x0010, dummy -> 0xA5 0x3C.
REQ-029 SHALL be verified with a wrap test: write at addr 0x0FFF the bytes 0x11 0x22; read addr 0x0000 -> 0x22.
REQ-030 SHALL be verified with an error sequence: opcode 0x7E -> qpi_err=1 and status 0x03; opcode 0x01 -> qpi_err=0 and status 0x01.
REQ-031 SHALL be verified with an abort: raise csb after one nibble of a write data byte -> memory unchanged, io tri-stated within 3 cycles, qpi_rdy=1.
REQ-032 SHALL be verified with bus sharing: csb high with io driven externally -> mlaccel_top never drives qpi_io0..3.
